mcif_rd_cmd: RTL and testbench

Read-side MCIF front end; consumes the `{len, base_addr, offset}` read commands issued by the DMA engines (weight, feature) and turns each into one AXI4 AR burst. Returns R-channel beats to the requester, tracks outstanding bursts against a fixed ceiling, and optionally checks beat count per burst. Sits between the DMA command generators and the AXI master port.

---
 rtl/mcif_rd_cmd_pkg.sv | 24 ++
 rtl/mcif_len_fifo.sv | 50 +++++
 rtl/mcif_rd_cmd.sv | 160 ++++++++++++++++
 tb/tb_mcif_rd_cmd.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mcif_rd_cmd_pkg.sv
// mcif_rd_cmd_pkg
// Shared definitions for the MCIF read command front end.
//   - Bit positions of the fields inside the read command payload
//     {len, base_addr, offset}; offset sits in the low 32 bits.
//   - AXI constants: INCR burst encoding and the ARSIZE derivation from
//     the data bus width.
`timescale 1ns/1ps

package mcif_rd_cmd_pkg;

    localparam int PD_OFFSET_LSB = 0;
    localparam int PD_OFFSET_W   = 32;
    localparam int PD_BASE_LSB   = 32;
    localparam int PD_BASE_W     = 32;
    localparam int PD_LEN_LSB    = 64;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;

    // ARSIZE encodes bytes-per-beat as a power of two.
    function automatic logic [2:0] axi_size(input int data_w);
        return 3'($clog2(data_w / 8));
    endfunction

endpackage

// File: rtl/mcif_len_fifo.sv
// mcif_len_fifo
// Small synchronous FIFO holding the len field of every issued AR burst so
// the R-side beat counter can compare against the burst it is receiving.
// Depth must be a power of two.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   push_i      : write data_i at the tail
//   data_i      : len of the burst just issued
//   pop_i       : drop the head entry
//   data_o      : head entry (valid when empty_o is low)
//   empty_o     : FIFO holds no entries
`timescale 1ns/1ps

module mcif_len_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             empty_o
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    // One extra pointer bit distinguishes full from empty.
    logic [PTR_W:0]   wr_ptr_q, rd_ptr_q;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign data_o  = mem_q[rd_ptr_q[PTR_W-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_ptr_q[PTR_W-1:0]] <= data_i;
    end

endmodule

// File: rtl/mcif_rd_cmd.sv
// mcif_rd_cmd
// Read-side MCIF front end. Each DMA read command {len, base_addr, offset}
// becomes one AXI4 INCR burst on AR; R beats are passed straight back to
// the requester. Outstanding bursts are limited to MAX_OUTSTANDING.
// Optional feature macro: MCIF_RD_LEN_CHECK_EN enables per-burst beat count
// checking (sticky len_err); without it len_err is tied low.
// Ports:
//   clk, rst_n                      : clock, asynchronous active-low reset
//   rd_req_vld/rdy/pd               : command handshake and payload
//   m_ar*                           : AXI read address channel
//   m_rvalid/rready/rdata/rlast     : AXI read data channel
//   rd_rsp_vld/rdy/pd               : response to requester {rlast, rdata}
//   idle                            : nothing held, nothing outstanding
//   len_err                         : sticky beat-count mismatch
`timescale 1ns/1ps

module mcif_rd_cmd
    import mcif_rd_cmd_pkg::*;
#(
    parameter int AXI_BURST_LEN   = 16,
    parameter int LOG2_BURST_LEN  = 4,
    parameter int DATA_W          = 256,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       rd_req_vld,
    output logic                       rd_req_rdy,
    input  logic [LOG2_BURST_LEN+63:0] rd_req_pd,
    output logic                       m_arvalid,
    input  logic                       m_arready,
    output logic [31:0]                m_araddr,
    output logic [7:0]                 m_arlen,
    output logic [2:0]                 m_arsize,
    output logic [1:0]                 m_arburst,
    input  logic                       m_rvalid,
    output logic                       m_rready,
    input  logic [DATA_W-1:0]          m_rdata,
    input  logic                       m_rlast,
    output logic                       rd_rsp_vld,
    input  logic                       rd_rsp_rdy,
    output logic [DATA_W:0]            rd_rsp_pd,
    output logic                       idle,
    output logic                       len_err
);

    localparam int CNT_W = $clog2(MAX_OUTSTANDING) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);

    if (AXI_BURST_LEN != (1 << LOG2_BURST_LEN)) begin : g_bad_burst_cfg
        $error("AXI_BURST_LEN must equal 2**LOG2_BURST_LEN");
    end

    logic                      cmd_vld_q, cmd_vld_d;
    logic [31:0]               cmd_addr_q, cmd_addr_d;
    logic [LOG2_BURST_LEN-1:0] cmd_len_q, cmd_len_d;
    logic [CNT_W-1:0]          outst_cnt_q, outst_cnt_d;

    logic req_fire, ar_fire, r_last_fire, cnt_dec;

    assign m_arvalid   = cmd_vld_q & (outst_cnt_q != CNT_MAX);
    assign ar_fire     = m_arvalid & m_arready;
    assign rd_req_rdy  = ~cmd_vld_q | ar_fire;
    assign req_fire    = rd_req_vld & rd_req_rdy;
    assign r_last_fire = m_rvalid & m_rready & m_rlast;
    // A last beat with nothing outstanding is a slave protocol error; the
    // counter stays at zero rather than wrapping.
    assign cnt_dec     = r_last_fire & (outst_cnt_q != '0);

    assign m_araddr  = cmd_addr_q;
    assign m_arlen   = 8'(cmd_len_q);
    assign m_arsize  = axi_size(DATA_W);
    assign m_arburst = AXI_BURST_INCR;

    assign rd_rsp_vld = m_rvalid;
    assign m_rready   = rd_rsp_rdy;
    assign rd_rsp_pd  = {m_rlast, m_rdata};

    assign idle = ~cmd_vld_q & (outst_cnt_q == '0);

    always_comb begin
        cmd_vld_d  = cmd_vld_q;
        cmd_addr_d = cmd_addr_q;
        cmd_len_d  = cmd_len_q;
        if (ar_fire) cmd_vld_d = 1'b0;
        if (req_fire) begin
            cmd_vld_d  = 1'b1;
            // Carry out of the 32-bit sum is intentionally dropped.
            cmd_addr_d = rd_req_pd[PD_BASE_LSB +: PD_BASE_W]
                       + rd_req_pd[PD_OFFSET_LSB +: PD_OFFSET_W];
            cmd_len_d  = rd_req_pd[PD_LEN_LSB +: LOG2_BURST_LEN];
        end
        outst_cnt_d = outst_cnt_q;
        if (ar_fire && !cnt_dec)      outst_cnt_d = outst_cnt_q + 1'b1;
        else if (!ar_fire && cnt_dec) outst_cnt_d = outst_cnt_q - 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_vld_q   <= 1'b0;
            cmd_addr_q  <= '0;
            cmd_len_q   <= '0;
            outst_cnt_q <= '0;
        end else begin
            cmd_vld_q   <= cmd_vld_d;
            cmd_addr_q  <= cmd_addr_d;
            cmd_len_q   <= cmd_len_d;
            outst_cnt_q <= outst_cnt_d;
        end
    end

`ifdef MCIF_RD_LEN_CHECK_EN
    logic [LOG2_BURST_LEN-1:0] head_len;
    logic                      fifo_empty;
    logic [LOG2_BURST_LEN-1:0] beat_cnt_q, beat_cnt_d;
    logic                      len_err_q, len_err_d;
    logic                      r_fire;

    assign r_fire = m_rvalid & m_rready;

    mcif_len_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .WIDTH (LOG2_BURST_LEN)
    ) u_len_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (ar_fire),
        .data_i  (cmd_len_q),
        .pop_i   (r_last_fire & ~fifo_empty),
        .data_o  (head_len),
        .empty_o (fifo_empty)
    );

    // beat_cnt is the zero-based index of the beat being accepted, so the
    // last beat of a burst is expected exactly when it equals len.
    always_comb begin
        beat_cnt_d = beat_cnt_q;
        if (r_last_fire)  beat_cnt_d = '0;
        else if (r_fire)  beat_cnt_d = beat_cnt_q + 1'b1;
        len_err_d = len_err_q;
        if (r_fire && !fifo_empty && (m_rlast != (beat_cnt_q == head_len)))
            len_err_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt_q <= '0;
            len_err_q  <= 1'b0;
        end else begin
            beat_cnt_q <= beat_cnt_d;
            len_err_q  <= len_err_d;
        end
    end

    assign len_err = len_err_q;
`else
    assign len_err = 1'b0;
`endif

endmodule

// File: tb/tb_mcif_rd_cmd.sv
`timescale 1ns/1ps

module tb_mcif_rd_cmd;

    logic         clk;
    logic         rst_n;
    logic         rd_req_vld;
    logic         rd_req_rdy;
    logic [67:0]  rd_req_pd;
    logic         m_arvalid;
    logic         m_arready;
    logic [31:0]  m_araddr;
    logic [7:0]   m_arlen;
    logic [2:0]   m_arsize;
    logic [1:0]   m_arburst;
    logic         m_rvalid;
    logic         m_rready;
    logic [255:0] m_rdata;
    logic         m_rlast;
    logic         rd_rsp_vld;
    logic         rd_rsp_rdy;
    logic [256:0] rd_rsp_pd;
    logic         idle;
    logic         len_err;

    int checks = 0;
    int errors = 0;

    mcif_rd_cmd dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rd_req_vld (rd_req_vld),
        .rd_req_rdy (rd_req_rdy),
        .rd_req_pd  (rd_req_pd),
        .m_arvalid  (m_arvalid),
        .m_arready  (m_arready),
        .m_araddr   (m_araddr),
        .m_arlen    (m_arlen),
        .m_arsize   (m_arsize),
        .m_arburst  (m_arburst),
        .m_rvalid   (m_rvalid),
        .m_rready   (m_rready),
        .m_rdata    (m_rdata),
        .m_rlast    (m_rlast),
        .rd_rsp_vld (rd_rsp_vld),
        .rd_rsp_rdy (rd_rsp_rdy),
        .rd_rsp_pd  (rd_rsp_pd),
        .idle       (idle),
        .len_err    (len_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change 1ns after the rising edge; checks run 1ns later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_burst(input int nbeats);
        for (int b = 0; b < nbeats; b++) begin
            m_rvalid   = 1'b1;
            m_rlast    = (b == nbeats - 1);
            m_rdata    = {8{32'(32'h5A5A_0000 + b)}};
            rd_rsp_rdy = 1'b1;
            step();
        end
        m_rvalid = 1'b0;
        m_rlast  = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; rd_req_vld = 1'b0; rd_req_pd = '0; m_arready = 1'b0;
        m_rvalid = 1'b0; m_rdata = '0; m_rlast = 1'b0; rd_rsp_rdy = 1'b0;
        #1;
        checks++; if (rd_req_rdy !== 1'b1) begin errors++; $display("FAIL reset_rdy got %b exp 1", rd_req_rdy); end
        checks++; if (m_arvalid !== 1'b0) begin errors++; $display("FAIL reset_arvalid got %b exp 0", m_arvalid); end
        checks++; if (idle !== 1'b1) begin errors++; $display("FAIL reset_idle got %b exp 1", idle); end
        checks++; if (len_err !== 1'b0) begin errors++; $display("FAIL reset_len_err got %b exp 0", len_err); end
        step(); step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_single();
        logic [255:0] rd;
        m_arready  = 1'b1;
        rd_req_vld = 1'b1;
        rd_req_pd  = {4'd3, 32'h1000_0000, 32'h0000_0400};
        step();
        rd_req_vld = 1'b0;
        #1;
        checks++; if (m_arvalid !== 1'b1) begin errors++; $display("FAIL single_arvalid got %b exp 1", m_arvalid); end
        checks++; if (m_araddr !== 32'h1000_0400) begin errors++; $display("FAIL single_araddr got %h exp 10000400", m_araddr); end
        checks++; if (m_arlen !== 8'd3) begin errors++; $display("FAIL single_arlen got %0d exp 3", m_arlen); end
        checks++; if (m_arsize !== 3'd5) begin errors++; $display("FAIL single_arsize got %0d exp 5", m_arsize); end
        checks++; if (m_arburst !== 2'b01) begin errors++; $display("FAIL single_arburst got %b exp 01", m_arburst); end
        checks++; if (idle !== 1'b0) begin errors++; $display("FAIL single_busy got %b exp 0", idle); end
        step();
        checks++; if (m_arvalid !== 1'b0) begin errors++; $display("FAIL single_arvalid_drop got %b exp 0", m_arvalid); end
        checks++; if (idle !== 1'b0) begin errors++; $display("FAIL single_outst got %b exp 0", idle); end
        for (int b = 0; b < 4; b++) begin
            rd         = {8{32'(32'hA5A5_0000 + b)}};
            m_rvalid   = 1'b1;
            m_rdata    = rd;
            m_rlast    = (b == 3);
            rd_rsp_rdy = 1'b1;
            #1;
            checks++; if (rd_rsp_vld !== 1'b1) begin errors++; $display("FAIL beat%0d_vld got %b exp 1", b, rd_rsp_vld); end
            checks++; if (rd_rsp_pd !== {(b == 3), rd}) begin errors++; $display("FAIL beat%0d_pd got %h exp %h", b, rd_rsp_pd, {(b == 3), rd}); end
            checks++; if (m_rready !== 1'b1) begin errors++; $display("FAIL beat%0d_rready got %b exp 1", b, m_rready); end
            step();
        end
        m_rvalid = 1'b0;
        m_rlast  = 1'b0;
        #1;
        checks++; if (idle !== 1'b1) begin errors++; $display("FAIL single_idle got %b exp 1", idle); end
        checks++; if (len_err !== 1'b0) begin errors++; $display("FAIL single_len_err got %b exp 0", len_err); end
    endtask

    task automatic test_wrap();
        m_arready  = 1'b1;
        rd_req_vld = 1'b1;
        rd_req_pd  = {4'd0, 32'hFFFF_FF00, 32'h0000_0200};
        step();
        rd_req_vld = 1'b0;
        #1;
        checks++; if (m_araddr !== 32'h0000_0100) begin errors++; $display("FAIL wrap_araddr got %h exp 00000100", m_araddr); end
        checks++; if (m_arlen !== 8'd0) begin errors++; $display("FAIL wrap_arlen got %0d exp 0", m_arlen); end
        step();
        send_burst(1);
        #1;
        checks++; if (idle !== 1'b1) begin errors++; $display("FAIL wrap_idle got %b exp 1", idle); end
    endtask

    task automatic test_backpressure();
        m_arready  = 1'b0;
        rd_req_vld = 1'b1;
        rd_req_pd  = {4'd7, 32'h0000_2000, 32'h0000_0020};
        step();
        rd_req_vld = 1'b0;
        for (int c = 0; c < 5; c++) begin
            #1;
            checks++; if (m_arvalid !== 1'b1) begin errors++; $display("FAIL bp%0d_arvalid got %b exp 1", c, m_arvalid); end
            checks++; if (m_araddr !== 32'h0000_2020) begin errors++; $display("FAIL bp%0d_araddr got %h exp 00002020", c, m_araddr); end
            checks++; if (m_arlen !== 8'd7) begin errors++; $display("FAIL bp%0d_arlen got %0d exp 7", c, m_arlen); end
            checks++; if (rd_req_rdy !== 1'b0) begin errors++; $display("FAIL bp%0d_rdy got %b exp 0", c, rd_req_rdy); end
            step();
        end
        m_rvalid   = 1'b1;
        rd_rsp_rdy = 1'b0;
        #1;
        checks++; if (m_rready !== 1'b0) begin errors++; $display("FAIL bp_rready got %b exp 0", m_rready); end
        checks++; if (rd_rsp_vld !== 1'b1) begin errors++; $display("FAIL bp_rsp_vld got %b exp 1", rd_rsp_vld); end
        m_rvalid  = 1'b0;
        m_arready = 1'b1;
        step();
        send_burst(8);
        #1;
        checks++; if (idle !== 1'b1) begin errors++; $display("FAIL bp_idle got %b exp 1", idle); end
    endtask

    task automatic test_ceiling_and_simultaneous();
        int cap = 0;
        int arf = 0;
        int beats = 0;
        m_arready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            rd_req_vld = 1'b1;
            rd_req_pd  = {4'd0, 32'h3000_0000, 32'(cap * 64)};
            #1;
            if (rd_req_vld && rd_req_rdy) cap++;
            if (m_arvalid && m_arready) arf++;
            step();
        end
        rd_req_vld = 1'b0;
        #1;
        checks++; if (cap !== 9) begin errors++; $display("FAIL ceil_captured got %0d exp 9", cap); end
        checks++; if (arf !== 8) begin errors++; $display("FAIL ceil_ar_count got %0d exp 8", arf); end
        checks++; if (m_arvalid !== 1'b0) begin errors++; $display("FAIL ceil_arvalid got %b exp 0", m_arvalid); end
        checks++; if (rd_req_rdy !== 1'b0) begin errors++; $display("FAIL ceil_rdy got %b exp 0", rd_req_rdy); end
        // One last beat frees a slot; the ninth AR may go the cycle after.
        m_rvalid = 1'b1; m_rlast = 1'b1; rd_rsp_rdy = 1'b1;
        #1;
        checks++; if (m_arvalid !== 1'b0) begin errors++; $display("FAIL ceil_hold got %b exp 0", m_arvalid); end
        step();
        m_rvalid = 1'b0; m_rlast = 1'b0;
        #1;
        checks++; if (m_arvalid !== 1'b1) begin errors++; $display("FAIL ceil_release got %b exp 1", m_arvalid); end
        checks++; if (m_araddr !== 32'h3000_0200) begin errors++; $display("FAIL ceil_9th_addr got %h exp 30000200", m_araddr); end
        // Count is 7: AR and last beat in the same cycle leave it at 7.
        m_rvalid = 1'b1; m_rlast = 1'b1;
        step();
        m_rvalid = 1'b0; m_rlast = 1'b0;
        #1;
        checks++; if (m_arvalid !== 1'b0) begin errors++; $display("FAIL simul_cmd_clear got %b exp 0", m_arvalid); end
        // With count 7 one more AR is allowed, a second one is not.
        rd_req_vld = 1'b1;
        rd_req_pd  = {4'd0, 32'h4000_0000, 32'h0};
        step();
        rd_req_vld = 1'b0;
        #1;
        checks++; if (m_arvalid !== 1'b1) begin errors++; $display("FAIL simul_below_max got %b exp 1", m_arvalid); end
        step();
        rd_req_vld = 1'b1;
        rd_req_pd  = {4'd0, 32'h4000_1000, 32'h0};
        #1;
        checks++; if (rd_req_rdy !== 1'b1) begin errors++; $display("FAIL simul_rdy got %b exp 1", rd_req_rdy); end
        step();
        rd_req_vld = 1'b0;
        #1;
        checks++; if (m_arvalid !== 1'b0) begin errors++; $display("FAIL simul_at_max got %b exp 0", m_arvalid); end
        // Eight outstanding plus one pending command: nine last beats drain it.
        for (int c = 0; c < 20; c++) begin
            if (idle) break;
            m_rvalid = 1'b1; m_rlast = 1'b1; rd_rsp_rdy = 1'b1;
            step();
            m_rvalid = 1'b0; m_rlast = 1'b0;
            beats++;
        end
        #1;
        checks++; if (beats !== 9) begin errors++; $display("FAIL drain_beats got %0d exp 9", beats); end
        checks++; if (idle !== 1'b1) begin errors++; $display("FAIL drain_idle got %b exp 1", idle); end
        checks++; if (len_err !== 1'b0) begin errors++; $display("FAIL drain_len_err got %b exp 0", len_err); end
    endtask

    task automatic test_len_err();
        logic exp_err;
`ifdef MCIF_RD_LEN_CHECK_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        m_arready  = 1'b1;
        rd_req_vld = 1'b1;
        rd_req_pd  = {4'd3, 32'h5000_0000, 32'h0};
        step();
        rd_req_vld = 1'b0;
        step();
        send_burst(3);
        #1;
        checks++; if (len_err !== exp_err) begin errors++; $display("FAIL len_err_set got %b exp %b", len_err, exp_err); end
        step(); step();
        checks++; if (len_err !== exp_err) begin errors++; $display("FAIL len_err_sticky got %b exp %b", len_err, exp_err); end
        checks++; if (idle !== 1'b1) begin errors++; $display("FAIL len_err_idle got %b exp 1", idle); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_wrap();
        test_backpressure();
        test_ceiling_and_simultaneous();
        test_len_err();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
